// File: rtl/cart_loader.sv
// Cart ROM loader: parks each host download word until the next CPU ce slot, writes it to the
// ROM dpram and captures header fields. Optional header checksum: CART_LOADER_CHECKSUM_EN.
module cart_loader #(
  parameter int ADDR_W = 24
) (
  input  logic              clk_sys,
  input  logic              reset_n,
  input  logic              ce,
  input  logic              dl_active,
  input  logic              ioctl_wr,
  input  logic [ADDR_W:0]   ioctl_addr,
  input  logic [15:0]       ioctl_dout,
  output logic              ioctl_wait,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [15:0]       mem_din,
  output logic              mem_we,
  output logic [7:0]        cart_cgb_flag,
  output logic [7:0]        cart_mbc_type,
  output logic [7:0]        cart_rom_size,
  output logic [7:0]        cart_ram_size,
  output logic [ADDR_W-1:0] words_loaded,
  output logic              hdr_ok,
  output logic              cart_ready
);

  typedef enum logic [1:0] {IDLE, PEND, WRITE, FINISH} state_e;

  // Header locations as word addresses (byte address >> 1).
  localparam logic [ADDR_W-1:0] W_HDR_LO = ADDR_W'(32'h09A);
  localparam logic [ADDR_W-1:0] W_CGB    = ADDR_W'(32'h0A1);
  localparam logic [ADDR_W-1:0] W_MBC    = ADDR_W'(32'h0A3);
  localparam logic [ADDR_W-1:0] W_SIZE   = ADDR_W'(32'h0A4);
  localparam logic [ADDR_W-1:0] W_CSUM   = ADDR_W'(32'h0A6);
  localparam logic [ADDR_W-1:0] W_MIN    = ADDR_W'(32'h0A8);

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [15:0]       data_q, data_d;
  logic [ADDR_W-1:0] wl_q;
  logic [7:0]        cgb_q, mbc_q, rom_q, ram_q;
  logic              dl_q, edge_en_q, fin_pend_q;
  logic              rdy_q, ok_q, rdy_ok;
  logic              dl_rise, dl_fall, do_write, do_finish;
  logic              unused_addr_lsb;

  assign unused_addr_lsb = ioctl_addr[0];

  // edge_en_q masks the first cycle after reset so dl_q can pick up the live level.
  assign dl_rise   = edge_en_q &  dl_active & ~dl_q;
  assign dl_fall   = edge_en_q & ~dl_active &  dl_q;
  assign do_write  = (state_q == WRITE);
  assign do_finish = (state_q == FINISH);

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    data_d  = data_q;
    case (state_q)
      IDLE: begin
        if ((fin_pend_q || dl_fall) && !dl_active) begin
          state_d = FINISH;
        end else if (ioctl_wr && dl_active) begin
          state_d = PEND;
          addr_d  = ioctl_addr[ADDR_W:1];
          data_d  = ioctl_dout;
        end
      end
      PEND:    if (ce) state_d = WRITE;
      WRITE:   state_d = IDLE;
      FINISH:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= IDLE;
      addr_q     <= '0;
      data_q     <= '0;
      dl_q       <= 1'b0;
      edge_en_q  <= 1'b0;
      fin_pend_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      addr_q    <= addr_d;
      data_q    <= data_d;
      dl_q      <= dl_active;
      edge_en_q <= 1'b1;
      if (dl_rise || do_finish) fin_pend_q <= 1'b0;
      else if (dl_fall)         fin_pend_q <= 1'b1;
    end
  end

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      wl_q <= '0;
    end else if (dl_rise) begin
      wl_q <= '0;
    end else if (do_write && wl_q != '1) begin
      wl_q <= wl_q + 1'b1;
    end
  end

  // Header bytes survive across downloads; only reset or a new header write replaces them.
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      cgb_q <= '0;
      mbc_q <= '0;
      rom_q <= '0;
      ram_q <= '0;
    end else if (do_write) begin
      if (addr_q == W_CGB) cgb_q <= data_q[15:8];
      if (addr_q == W_MBC) mbc_q <= data_q[15:8];
      if (addr_q == W_SIZE) begin
        rom_q <= data_q[7:0];
        ram_q <= data_q[15:8];
      end
    end
  end

`ifdef CART_LOADER_CHECKSUM_EN
  logic [7:0] acc_q;
  logic [7:0] acc_lo;

  // acc_lo folds in the low byte; the high byte of the last word is the stored checksum.
  assign acc_lo = acc_q - data_q[7:0] - 8'd1;

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      acc_q <= '0;
      ok_q  <= 1'b0;
    end else if (dl_rise) begin
      acc_q <= '0;
      ok_q  <= 1'b0;
    end else if (do_write) begin
      if (addr_q >= W_HDR_LO && addr_q < W_CSUM) begin
        acc_q <= acc_lo - data_q[15:8] - 8'd1;
      end else if (addr_q == W_CSUM) begin
        acc_q <= acc_lo;
        ok_q  <= (acc_lo == data_q[15:8]);
      end
    end
  end

  assign rdy_ok = ok_q;
`else
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n)       ok_q <= 1'b0;
    else if (dl_rise)   ok_q <= 1'b0;
    else if (do_finish) ok_q <= 1'b1;
  end

  assign rdy_ok = 1'b1;
`endif

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n)       rdy_q <= 1'b0;
    else if (dl_rise)   rdy_q <= 1'b0;
    else if (do_finish) rdy_q <= (wl_q >= W_MIN) && rdy_ok;
  end

  // Wait is decoded from state so an async reset drops it immediately.
  assign ioctl_wait    = (state_q == PEND) || (state_q == WRITE);
  assign mem_we        = do_write;
  assign mem_addr      = addr_q;
  assign mem_din       = data_q;
  assign words_loaded  = wl_q;
  assign cart_cgb_flag = cgb_q;
  assign cart_mbc_type = mbc_q;
  assign cart_rom_size = rom_q;
  assign cart_ram_size = ram_q;
  assign hdr_ok        = ok_q;
  assign cart_ready    = rdy_q;

endmodule

// File: tb/tb_cart_loader.sv
// Randomized self-checking bench for cart_loader; header/checksum expectations come from a
// byte-array model of the cartridge image.
module tb_cart_loader;
  localparam int AW = 8;
`ifdef CART_LOADER_CHECKSUM_EN
  localparam bit CSUM = 1'b1;
`else
  localparam bit CSUM = 1'b0;
`endif

  logic          clk_sys = 1'b0, reset_n = 1'b0, ce = 1'b0, dl_active = 1'b0, ioctl_wr = 1'b0;
  logic [AW:0]   ioctl_addr = '0;
  logic [15:0]   ioctl_dout = '0;
  logic          ioctl_wait, mem_we, hdr_ok, cart_ready;
  logic [AW-1:0] mem_addr, words_loaded;
  logic [15:0]   mem_din;
  logic [7:0]    cart_cgb_flag, cart_mbc_type, cart_rom_size, cart_ram_size;

  cart_loader #(.ADDR_W(AW)) dut (
    .clk_sys(clk_sys), .reset_n(reset_n), .ce(ce), .dl_active(dl_active),
    .ioctl_wr(ioctl_wr), .ioctl_addr(ioctl_addr), .ioctl_dout(ioctl_dout),
    .ioctl_wait(ioctl_wait), .mem_addr(mem_addr), .mem_din(mem_din), .mem_we(mem_we),
    .cart_cgb_flag(cart_cgb_flag), .cart_mbc_type(cart_mbc_type),
    .cart_rom_size(cart_rom_size), .cart_ram_size(cart_ram_size),
    .words_loaded(words_loaded), .hdr_ok(hdr_ok), .cart_ready(cart_ready)
  );

  int            chk_cnt = 0, pass_cnt = 0, we_cnt = 0, rdy_rise = 0;
  logic          rdy_prev = 1'b0;
  logic [AW-1:0] wa_q[$];
  logic [15:0]   wd_q[$];
  logic [7:0]    hdr [0:335];
  int unsigned   cyc = 0;

  always #5 clk_sys = ~clk_sys;

  // ce high for one cycle in every eight, changed mid-cycle.
  initial forever begin
    @(posedge clk_sys); #2;
    ce = (cyc % 8 == 7);
    cyc++;
  end

  initial forever begin
    @(negedge clk_sys);
    if (mem_we === 1'b1) begin
      we_cnt++;
      wa_q.push_back(mem_addr);
      wd_q.push_back(mem_din);
    end
    if (cart_ready === 1'b1 && !rdy_prev) rdy_rise++;
    rdy_prev = cart_ready;
  end

  initial begin
    #800000;
    $display("FAIL watchdog: time limit reached, got running want finished");
    $fatal(1, "watchdog");
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk_sys);
  endtask

  task automatic send_word(input logic [AW:0] a, input logic [15:0] d, input bit bad,
                           input bit drop_dl, output bit to);
    int n;
    ioctl_addr = a; ioctl_dout = d; ioctl_wr = 1'b1;
    tick(1);
    ioctl_wr = 1'b0;
    if (drop_dl) dl_active = 1'b0;
    if (bad) begin
      ioctl_addr = {~a[AW:1], 1'b0}; ioctl_dout = ~d; ioctl_wr = 1'b1;
      tick(1);
      ioctl_wr = 1'b0;
    end
    n = 0;
    while (ioctl_wait && n < 40) begin tick(1); n++; end
    to = ioctl_wait;
  endtask

  task automatic build_header(input bit corrupt);
    logic [7:0] x;
    for (int i = 0; i < 336; i++) hdr[i] = 8'($urandom);
    hdr['h143] = 8'h80; hdr['h147] = 8'h13; hdr['h148] = 8'h05; hdr['h149] = 8'h03;
    x = 8'h00;
    for (int i = 'h134; i <= 'h14C; i++) x = x - hdr[i] - 8'd1;
    hdr['h14D] = x ^ {7'd0, corrupt};
  endtask

  function automatic bit hdr_sum_ok();
    logic [7:0] x;
    x = 8'h00;
    for (int i = 'h134; i <= 'h14C; i++) x = x - hdr[i] - 8'd1;
    return x == hdr['h14D];
  endfunction

  task automatic stream_header(input bit late, output int errs);
    bit to;
    errs = 0;
    dl_active = 1'b1; tick(2);
    for (int w = 0; w < 168; w++) begin
      send_word(9'(w * 2), {hdr[2*w+1], hdr[2*w]}, ($urandom_range(0, 3) == 0),
                late && (w == 167), to);
      if (to || wa_q.size() != 1) errs++;
      else if (wa_q[0] !== 8'(w) || wd_q[0] !== {hdr[2*w+1], hdr[2*w]}) errs++;
      wa_q.delete(); wd_q.delete();
    end
  endtask

  task automatic test_reset();
    reset_n = 1'b0; tick(3);
    chk_cnt++; if (ioctl_wait !== 1'b0) $display("FAIL reset_wait: got %b want 0", ioctl_wait); else pass_cnt++;
    chk_cnt++; if (mem_we !== 1'b0) $display("FAIL reset_we: got %b want 0", mem_we); else pass_cnt++;
    chk_cnt++; if (mem_addr !== '0 || mem_din !== '0) $display("FAIL reset_mem: got %h/%h want 0/0", mem_addr, mem_din); else pass_cnt++;
    chk_cnt++; if (words_loaded !== '0) $display("FAIL reset_wl: got %h want 0", words_loaded); else pass_cnt++;
    chk_cnt++; if ({cart_cgb_flag, cart_mbc_type, cart_rom_size, cart_ram_size} !== 32'h0)
      $display("FAIL reset_hdr: got %h want 0", {cart_cgb_flag, cart_mbc_type, cart_rom_size, cart_ram_size}); else pass_cnt++;
    chk_cnt++; if ({hdr_ok, cart_ready} !== 2'b00) $display("FAIL reset_flags: got %b want 00", {hdr_ok, cart_ready}); else pass_cnt++;
    reset_n = 1'b1; tick(5);
    chk_cnt++; if ({hdr_ok, cart_ready, ioctl_wait} !== 3'b000) $display("FAIL reset_release: got %b want 000", {hdr_ok, cart_ready, ioctl_wait}); else pass_cnt++;
  endtask

  task automatic test_single_write();
    int n, we0;
    dl_active = 1'b1; tick(2);
    n = 0;
    while (!ce && n < 16) begin tick(1); n++; end
    we0 = we_cnt;
    ioctl_addr = 9'h010; ioctl_dout = 16'hBEEF; ioctl_wr = 1'b1;
    tick(1);
    ioctl_wr = 1'b0;
    chk_cnt++; if (ioctl_wait !== 1'b1) $display("FAIL sw_wait_set: got %b want 1", ioctl_wait); else pass_cnt++;
    n = 0;
    while (mem_we !== 1'b1 && n < 20) begin tick(1); n++; end
    chk_cnt++; if (n != 8) $display("FAIL sw_latency: got %0d want 8 cycles", n); else pass_cnt++;
    chk_cnt++; if (mem_addr !== 8'h08 || mem_din !== 16'hBEEF) $display("FAIL sw_data: got %h/%h want 08/beef", mem_addr, mem_din); else pass_cnt++;
    tick(1);
    chk_cnt++; if (ioctl_wait !== 1'b0) $display("FAIL sw_wait_clr: got %b want 0", ioctl_wait); else pass_cnt++;
    chk_cnt++; if (words_loaded !== 8'd1) $display("FAIL sw_wl: got %0d want 1", words_loaded); else pass_cnt++;
    chk_cnt++; if (we_cnt - we0 != 1) $display("FAIL sw_pulses: got %0d want 1", we_cnt - we0); else pass_cnt++;
    wa_q.delete(); wd_q.delete();
    dl_active = 1'b0; tick(4);
  endtask

  task automatic test_random_writes();
    int errs, we0;
    bit to;
    logic [AW:0] a;
    logic [15:0] d;
    errs = 0;
    dl_active = 1'b1; tick(2);
    chk_cnt++; if (words_loaded !== '0) $display("FAIL rw_rise_clear: got %0d want 0", words_loaded); else pass_cnt++;
    for (int i = 0; i < 24; i++) begin
      a = 9'($urandom_range(0, 127) * 2);
      d = 16'($urandom);
      send_word(a, d, ($urandom_range(0, 1) == 1), 1'b0, to);
      if (to || wa_q.size() != 1) errs++;
      else if (wa_q[0] !== a[AW:1] || wd_q[0] !== d) errs++;
      wa_q.delete(); wd_q.delete();
    end
    chk_cnt++; if (errs != 0) $display("FAIL rw_writes: got %0d bad want 0", errs); else pass_cnt++;
    chk_cnt++; if (words_loaded !== 8'd24) $display("FAIL rw_wl: got %0d want 24", words_loaded); else pass_cnt++;
    dl_active = 1'b0; tick(4);
    we0 = we_cnt;
    ioctl_addr = 9'h020; ioctl_dout = 16'h1234; ioctl_wr = 1'b1;
    tick(1);
    ioctl_wr = 1'b0;
    tick(12);
    chk_cnt++; if (we_cnt != we0 || ioctl_wait !== 1'b0) $display("FAIL rw_no_dl: got %0d writes wait %b want 0 0", we_cnt - we0, ioctl_wait); else pass_cnt++;
  endtask

  task automatic test_saturation();
    int errs, exp_wl;
    bit to;
    errs = 0; exp_wl = 0;
    dl_active = 1'b1; tick(2);
    for (int i = 0; i < 260; i++) begin
      send_word(9'($urandom_range(0, 127) * 2), 16'($urandom), 1'b0, 1'b0, to);
      if (to) errs++;
      wa_q.delete(); wd_q.delete();
      if (exp_wl < (1 << AW) - 1) exp_wl++;
      if (i == 199) begin
        chk_cnt++; if (words_loaded !== 8'(exp_wl)) $display("FAIL sat_mid: got %0d want %0d", words_loaded, exp_wl); else pass_cnt++;
      end
    end
    chk_cnt++; if (words_loaded !== 8'(exp_wl) || errs != 0) $display("FAIL sat_end: got %0d (to %0d) want %0d", words_loaded, errs, exp_wl); else pass_cnt++;
    dl_active = 1'b0; tick(4);
  endtask

  task automatic test_header(input bit corrupt);
    int errs;
    logic exp_ok;
    build_header(corrupt);
    exp_ok = CSUM ? hdr_sum_ok() : 1'b1;
    stream_header(1'b0, errs);
    chk_cnt++; if (errs != 0) $display("FAIL hdr_writes: got %0d bad want 0", errs); else pass_cnt++;
    dl_active = 1'b0; tick(2);
    chk_cnt++; if (hdr_ok !== exp_ok) $display("FAIL hdr_ok c%0d: got %b want %b", corrupt, hdr_ok, exp_ok); else pass_cnt++;
    chk_cnt++; if (cart_ready !== exp_ok) $display("FAIL hdr_ready c%0d: got %b want %b", corrupt, cart_ready, exp_ok); else pass_cnt++;
    chk_cnt++; if ({cart_cgb_flag, cart_mbc_type, cart_rom_size, cart_ram_size} !== {hdr['h143], hdr['h147], hdr['h148], hdr['h149]})
      $display("FAIL hdr_fields: got %h want %h", {cart_cgb_flag, cart_mbc_type, cart_rom_size, cart_ram_size},
               {hdr['h143], hdr['h147], hdr['h148], hdr['h149]}); else pass_cnt++;
    chk_cnt++; if (words_loaded !== 8'd168) $display("FAIL hdr_wl: got %0d want 168", words_loaded); else pass_cnt++;
    tick(2);
  endtask

  task automatic test_short_image();
    int errs;
    bit to;
    errs = 0;
    dl_active = 1'b1; tick(2);
    chk_cnt++; if ({cart_ready, hdr_ok, words_loaded} !== 10'd0) $display("FAIL si_rise_clear: got %b/%b/%0d want 0/0/0", cart_ready, hdr_ok, words_loaded); else pass_cnt++;
    for (int w = 0; w < 64; w++) begin
      send_word(9'(w * 2), 16'($urandom), 1'b0, 1'b0, to);
      if (to || wa_q.size() != 1 || wa_q[0] !== 8'(w)) errs++;
      wa_q.delete(); wd_q.delete();
    end
    dl_active = 1'b0; tick(4);
    chk_cnt++; if (errs != 0 || cart_ready !== 1'b0) $display("FAIL si_ready: got %b (bad %0d) want 0", cart_ready, errs); else pass_cnt++;
    chk_cnt++; if (hdr_ok !== !CSUM) $display("FAIL si_hdr_ok: got %b want %b", hdr_ok, !CSUM); else pass_cnt++;
    chk_cnt++; if ({cart_cgb_flag, cart_mbc_type, cart_rom_size, cart_ram_size} !== {hdr['h143], hdr['h147], hdr['h148], hdr['h149]})
      $display("FAIL si_hold: got %h want %h", {cart_cgb_flag, cart_mbc_type, cart_rom_size, cart_ram_size},
               {hdr['h143], hdr['h147], hdr['h148], hdr['h149]}); else pass_cnt++;
  endtask

  task automatic test_late_edge();
    int errs, r0;
    build_header(1'b0);
    r0 = rdy_rise;
    stream_header(1'b1, errs);
    tick(10);
    chk_cnt++; if (errs != 0) $display("FAIL le_writes: got %0d bad want 0", errs); else pass_cnt++;
    chk_cnt++; if (rdy_rise - r0 != 1) $display("FAIL le_rises: got %0d want 1", rdy_rise - r0); else pass_cnt++;
    chk_cnt++; if (cart_ready !== 1'b1 || words_loaded !== 8'd168) $display("FAIL le_ready: got %b/%0d want 1/168", cart_ready, words_loaded); else pass_cnt++;
  endtask

  task automatic test_reset_mid_pend();
    int we0;
    dl_active = 1'b1; tick(2);
    ioctl_addr = 9'h0F2; ioctl_dout = 16'hA55A; ioctl_wr = 1'b1;
    tick(1);
    ioctl_wr = 1'b0;
    chk_cnt++; if (ioctl_wait !== 1'b1) $display("FAIL rp_wait_set: got %b want 1", ioctl_wait); else pass_cnt++;
    we0 = we_cnt;
    #2 reset_n = 1'b0;
    #1;
    chk_cnt++; if (ioctl_wait !== 1'b0 || mem_we !== 1'b0) $display("FAIL rp_async: got wait %b we %b want 0 0", ioctl_wait, mem_we); else pass_cnt++;
    tick(3);
    dl_active = 1'b0;
    chk_cnt++; if (mem_addr !== '0 || mem_din !== '0 || words_loaded !== '0) $display("FAIL rp_mem: got %h/%h/%h want 0", mem_addr, mem_din, words_loaded); else pass_cnt++;
    chk_cnt++; if ({cart_cgb_flag, cart_mbc_type, cart_rom_size, cart_ram_size, hdr_ok, cart_ready} !== 34'h0)
      $display("FAIL rp_hdr: got %h %b%b want 0", {cart_cgb_flag, cart_mbc_type, cart_rom_size, cart_ram_size}, hdr_ok, cart_ready); else pass_cnt++;
    reset_n = 1'b1; tick(12);
    chk_cnt++; if (we_cnt != we0) $display("FAIL rp_no_we: got %0d pulses want 0", we_cnt - we0); else pass_cnt++;
    chk_cnt++; if ({hdr_ok, cart_ready, ioctl_wait} !== 3'b000) $display("FAIL rp_no_edge: got %b want 000", {hdr_ok, cart_ready, ioctl_wait}); else pass_cnt++;
  endtask

  initial begin
    test_reset();
    test_single_write();
    test_random_writes();
    test_saturation();
    test_header(1'b0);
    test_short_image();
    test_header(1'b1);
    test_late_edge();
    test_reset_mid_pend();
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule

// File: doc/cart_loader.md
CART_LOADER -- requirements
Module: cart_loader

Interface
REQ-001 SHALL have parameter ADDR_W, default 24, the ROM word-address width (16-bit words).
REQ-002 SHALL have port clk_sys, input, 1 bit, the system clock; every register is clocked on its rising edge.
REQ-003 SHALL have port reset_n, input, 1 bit, the reset: asynchronous, active-low.
REQ-004 SHALL have port ce, input, 1 bit, the one-cycle memory-write strobe (CPU clock enable).
REQ-005 SHALL have port dl_active, input, 1 bit, the cart-download-in-progress flag.
REQ-006 SHALL have port ioctl_wr, input, 1 bit, a one-cycle strobe meaning a download word is valid.
REQ-007 SHALL have port ioctl_addr, input, ADDR_W+1 bits, the download byte address (always even).
REQ-008 SHALL have port ioctl_dout, input, 16 bits, the download word: [7:0] is the byte at addr, [15:8] the byte at addr+1.
REQ-009 SHALL have port ioctl_wait, output, 1 bit, backpressure to the host.
REQ-010 SHALL have ports mem_addr (output, ADDR_W bits), mem_din (output, 16 bits) and mem_we (output, 1 bit), forming the ROM dpram write port.
REQ-011 SHALL have ports cart_cgb_flag, cart_mbc_type, cart_rom_size and cart_ram_size, each output, 8 bits, holding the captured header bytes.
REQ-012 SHALL have port words_loaded, output, ADDR_W bits, the count of words written this download.
REQ-013 SHALL have port hdr_ok, output, 1 bit, the header-checksum result.
REQ-014 SHALL have port cart_ready, output, 1 bit, meaning the ROM image is complete and valid to run.

Function
REQ-015 SHALL implement FSM states IDLE, PEND, WRITE and FINISH.
REQ-016 IDLE: on ioctl_wr && dl_active SHALL latch addr[ADDR_W:1] and data, set ioctl_wait=1 in the same edge, and go to PEND; ioctl_wr with dl_active=0 SHALL be ignored.
REQ-017 PEND: on the first ce=1 cycle SHALL go to WRITE; the ce cycle that coincides with the entry edge SHALL NOT count.
REQ-018 WRITE: mem_we=1 for exactly one clk_sys cycle with the latched mem_addr/mem_din; SHALL then clear ioctl_wait, increment words_loaded, and return to IDLE.
REQ-019 ioctl_wr arriving while not in IDLE is a host protocol violation; it SHALL be dropped, and the latched word SHALL be unchanged.
REQ-020 A rising edge of dl_active SHALL clear cart_ready, hdr_ok, words_loaded and the checksum accumulator.
REQ-021 A falling edge of dl_active SHALL enter FINISH once the FSM is in IDLE (any pending write completes first).
REQ-022 FINISH SHALL last one cycle, set cart_ready=1 iff words_loaded is greater than or equal to 0xA8 (header fully received), then return to IDLE.
REQ-023 Header capture SHALL occur on the WRITE cycle according to the byte address of the written word:
- word 0x142: cart_cgb_flag <= [15:8].
- word 0x146: cart_mbc_type <= [15:8].
- word 0x148: cart_rom_size <= [7:0], cart_ram_size <= [15:8].
REQ-024 words_loaded SHALL saturate at all-ones and SHALL NOT wrap.
REQ-025 The address SHALL pass through unmodified; writes beyond 2^ADDR_W words SHALL be truncated silently (upper bit ignored).
REQ-026 Header fields SHALL hold their values across downloads until overwritten.

Reset
REQ-027 While reset_n=0, the block SHALL force: state IDLE; ioctl_wait, mem_we, cart_ready and hdr_ok 0; mem_addr, mem_din and words_loaded 0; all header bytes 0x00.
REQ-028 Reset mid-PEND SHALL drop the pending word with no mem_we pulse, and ioctl_wait SHALL fall asynchronously.
REQ-029 After reset release, the dl_active edge detector SHALL take the current dl_active level as its prior value, so no spurious edge is generated.

Configuration
REQ-030 With macro CART_LOADER_CHECKSUM_EN defined, the block SHALL compute the header checksum over bytes 0x134..0x14C with an 8-bit accumulator: x = x - byte - 1, starting at 0.
- The block SHALL compare x with byte 0x14D (taken from [15:8] of word 0x14C).
- hdr_ok SHALL equal the result of that compare, registered on the WRITE of word 0x14C.
- cart_ready in FINISH SHALL additionally require hdr_ok=1.
REQ-031 Without CART_LOADER_CHECKSUM_EN, no accumulator SHALL exist, hdr_ok SHALL be set to 1 in FINISH, and cart_ready SHALL depend only on the REQ-022 condition.

Verification
REQ-032 Single write: ioctl_wr with addr 0x000010 and dout 0xBEEF, ce every 8 cycles -> ioctl_wait=1 the next cycle; one mem_we pulse with mem_addr 0x000008 and mem_din 0xBEEF after the next ce; ioctl_wait then 0; words_loaded=1.
REQ-033 Header capture: stream a 0x150-byte header with 0x143=0x80, 0x147=0x13, 0x148=0x05, 0x149=0x03 -> cart_cgb_flag=0x80, cart_mbc_type=0x13, cart_rom_size=0x05, cart_ram_size=0x03.
REQ-034 Checksum (macro on): header with a correct 0x14D -> hdr_ok=1 and cart_ready=1 one cycle after dl_active falls; same header with 0x14D XOR 0x01 -> hdr_ok=0 and cart_ready=0.
REQ-035 Short image: dl_active falls after 0x40 words -> cart_ready stays 0.
REQ-036 Reset mid-PEND: pull reset_n low while ioctl_wait=1 -> ioctl_wait=0 immediately; no mem_we pulse; all outputs at their REQ-027 values.
REQ-037 Late edge: dl_active falls while in PEND -> the write completes, then FINISH; cart_ready becomes 1 exactly once.
